// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the gated frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE
  } state_t;

  localparam int unsigned SETTLE_CYCLES = 3;
  localparam int unsigned SYS_CLK_HZ    = 100_000_000;

endpackage

// File: rtl/freq_meter_if.sv
// Control/result bundle of freq_meter. FREQ_METER_DUTY_EN adds high_count.
interface freq_meter_if #(
  parameter int unsigned CNT_W = 27
);

  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] freq_count;
  logic             valid;
  logic             overflow;
  logic             busy;
`ifdef FREQ_METER_DUTY_EN
  logic [CNT_W-1:0] high_count;

  modport master (
    output enable, sig_in,
    input  freq_count, valid, overflow, busy, high_count
  );

  modport slave (
    input  enable, sig_in,
    output freq_count, valid, overflow, busy, high_count
  );
`else
  modport master (
    output enable, sig_in,
    input  freq_count, valid, overflow, busy
  );

  modport slave (
    input  enable, sig_in,
    output freq_count, valid, overflow, busy
  );
`endif

endinterface

// File: rtl/freq_meter_sync_edge_detect.sv
// Two-flop synchronizer plus a third flop for rising-edge detection.
module sync_edge_detect (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pulse
);

  logic s1, s2, s3;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync_out   = s2;
  assign rise_pulse = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: rising edges of sig_in over GATE_CYCLES clocks.
// Optional FREQ_METER_DUTY_EN also counts synchronized-high cycles per window.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic          CLK100MHZ,
  input  logic          CPU_RESETN,
  freq_meter_if.slave   bus
);

  localparam int unsigned      GW          = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST   = GW'(GATE_CYCLES - 1);
  localparam logic [1:0]       SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [1:0]       settle_cnt;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_next;
  logic             sat, sat_next, edge_at_max;
  logic [CNT_W-1:0] freq_q;
  logic             overflow_q, valid_q, busy_q;
  logic             sig_rise;

`ifdef FREQ_METER_DUTY_EN
  logic             sig_sync;
  logic [CNT_W-1:0] hi_cnt, hi_next, high_q;
`else
  logic             sync_unused;
`endif

  sync_edge_detect u_sync (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .async_in   (bus.sig_in),
`ifdef FREQ_METER_DUTY_EN
    .sync_out   (sig_sync),
`else
    .sync_out   (sync_unused),
`endif
    .rise_pulse (sig_rise)
  );

  // Next-count values include the current cycle's edge, so the final window
  // cycle is folded into the published result.
  always_comb begin
    edge_at_max = &edge_cnt;
    edge_next   = edge_at_max ? edge_cnt : edge_cnt + CNT_W'(sig_rise);
    sat_next    = sat | (edge_at_max & sig_rise);
`ifdef FREQ_METER_DUTY_EN
    hi_next     = (&hi_cnt) ? hi_cnt : hi_cnt + CNT_W'(sig_sync);
`endif
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state      <= IDLE;
      settle_cnt <= '0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      freq_q     <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef FREQ_METER_DUTY_EN
      hi_cnt     <= '0;
      high_q     <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.enable) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            busy_q     <= 1'b1;
          end
        end
        SETTLE: begin
          if (!bus.enable) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state    <= MEASURE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
`ifdef FREQ_METER_DUTY_EN
            hi_cnt   <= '0;
`endif
          end else begin
            settle_cnt <= settle_cnt + 2'd1;
          end
        end
        MEASURE: begin
          if (gate_cnt == GATE_LAST) begin
            // Publish and restart in one cycle; the valid cycle is gate 0
            // of the next window.
            freq_q     <= edge_next;
            overflow_q <= sat_next;
            valid_q    <= 1'b1;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
`ifdef FREQ_METER_DUTY_EN
            high_q     <= hi_next;
            hi_cnt     <= '0;
`endif
            if (!bus.enable) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else if (!bus.enable) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_next;
            sat      <= sat_next;
`ifdef FREQ_METER_DUTY_EN
            hi_cnt   <= hi_next;
`endif
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.freq_count = freq_q;
  assign bus.overflow   = overflow_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = busy_q;
`ifdef FREQ_METER_DUTY_EN
  assign bus.high_count = high_q;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: two instances (wide and 4-bit counter)
// share stimulus; a window-level reference model predicts every result.
module tb_freq_meter;
  import freq_meter_pkg::*;

  localparam int unsigned GATE  = 1000;
  localparam int unsigned W_A   = 27;
  localparam int unsigned W_S   = 4;
  localparam int unsigned MAX_A = (1 << W_A) - 1;
  localparam int unsigned MAX_S = (1 << W_S) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic sig_in = 1'b0;

  always #5 clk = ~clk;

  freq_meter_if #(.CNT_W(W_A)) bus_a ();
  freq_meter_if #(.CNT_W(W_S)) bus_s ();

  assign bus_a.enable = enable;
  assign bus_a.sig_in = sig_in;
  assign bus_s.enable = enable;
  assign bus_s.sig_in = sig_in;

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(W_A)) u_dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus_a)
  );

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(W_S)) u_sat (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus_s)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int unsigned sat_to(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- square-wave generator ----------------
  int unsigned req_p = 10, req_h = 5;
  int unsigned cur_p = 10, cur_h = 5, phase = 0;

  initial begin
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (phase == 0) begin
        cur_p = req_p;
        cur_h = req_h;
      end
      sig_in = (phase < cur_h);
      phase  = (phase + 1 >= cur_p) ? 0 : phase + 1;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned due;
    int unsigned edges;
    int unsigned highs;
  } exp_t;

  exp_t        exp_q[$];
  bit          x_hist[65536];
  bit          in_settle = 1'b0, in_window = 1'b0, m_busy = 1'b0;
  int unsigned settle_start = 0, win_start = 0;

  // Sync path makes the value sampled at clock n visible as s2 during cycle n+1.
  task automatic push_window();
    exp_t e;
    e.due   = cyc;
    e.edges = 0;
    e.highs = 0;
    for (int unsigned c = win_start; c < win_start + GATE; c++) begin
      if (x_hist[c-1] && !x_hist[c-2]) e.edges++;
      if (x_hist[c-1]) e.highs++;
    end
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    x_hist[cyc] = sig_in;
    if (!rst_n) begin
      in_settle = 1'b0;
      in_window = 1'b0;
      exp_q.delete();
    end else if (in_window) begin
      if (cyc - win_start == GATE) begin
        push_window();
        if (enable) win_start = cyc;
        else        in_window = 1'b0;
      end else if (!enable) begin
        in_window = 1'b0;
      end
    end else if (in_settle) begin
      if (!enable) begin
        in_settle = 1'b0;
      end else if (cyc - settle_start == SETTLE_CYCLES) begin
        in_settle = 1'b0;
        in_window = 1'b1;
        win_start = cyc;
      end
    end else if (enable) begin
      in_settle    = 1'b1;
      settle_start = cyc;
    end
    m_busy = in_settle | in_window;
  end

  // ---------------- monitor ----------------
  int unsigned last_edges = 0, last_highs = 0;

  always @(negedge clk) begin
    exp_t e;
    bit   due;
    if (!rst_n) begin
      last_edges = 0;
      last_highs = 0;
    end
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      check("missing_valid", 0, 1);
      void'(exp_q.pop_front());
    end
    due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    if (due) begin
      e = exp_q.pop_front();
      last_edges = e.edges;
      last_highs = e.highs;
    end
    check("valid_a", bus_a.valid, due);
    check("valid_s", bus_s.valid, due);
    check("freq_a", bus_a.freq_count, sat_to(last_edges, MAX_A));
    check("ovf_a", bus_a.overflow, last_edges > MAX_A);
    check("freq_s", bus_s.freq_count, sat_to(last_edges, MAX_S));
    check("ovf_s", bus_s.overflow, last_edges > MAX_S);
    check("busy_a", bus_a.busy, m_busy);
    check("busy_s", bus_s.busy, m_busy);
`ifdef FREQ_METER_DUTY_EN
    check("high_a", bus_a.high_count, sat_to(last_highs, MAX_A));
    check("high_s", bus_s.high_count, sat_to(last_highs, MAX_S));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic run(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int unsigned limit);
    int unsigned k = 0;
    while (!bus_a.valid && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!bus_a.valid) check("valid_timeout", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_freq_a"}, bus_a.freq_count, 0);
    check({tag, "_ovf_a"}, bus_a.overflow, 0);
    check({tag, "_valid_a"}, bus_a.valid, 0);
    check({tag, "_busy_a"}, bus_a.busy, 0);
    check({tag, "_freq_s"}, bus_s.freq_count, 0);
    check({tag, "_ovf_s"}, bus_s.overflow, 0);
    check({tag, "_valid_s"}, bus_s.valid, 0);
    check({tag, "_busy_s"}, bus_s.busy, 0);
  endtask

  initial begin
    int unsigned p, h;
    rst_n  = 1'b0;
    enable = 1'b0;
    run(3);
    check_zero("reset");
    #2 rst_n = 1'b1;
    run(2);
    enable = 1'b1;

    // 10-clock period, 50% duty: 100 edges per window
    run(3 * GATE + 10);

    // fast signal saturates the 4-bit counter, then period 100
    req_p = 4;   req_h = 2;
    run(GATE + 20);
    req_p = 100; req_h = $urandom_range(2, 98);
    run(2 * GATE);

    // abort mid-window, then restart
    wait_valid(GATE + 10);
    run(500);
    enable = 1'b0;
    run(20);
    enable = 1'b1;
    run(GATE + 20);

    // asynchronous reset mid-window
    run(300);
    @(negedge clk);
    #($urandom_range(1, 3)) rst_n = 1'b0;
    #1 check_zero("async_rst");
    repeat (2) @(negedge clk);
    #($urandom_range(1, 3)) rst_n = 1'b1;
    run(GATE + 20);

    // constant high, then constant low
    req_p = 50; req_h = 50;
    run(2 * GATE);
    req_h = 0;
    run(2 * GATE);

    // 30% duty
    req_p = 10; req_h = 3;
    run(2 * GATE);

    // randomized periods and occasional enable glitches
    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(4, 200);
      h = $urandom_range(2, p - 2);
      req_p = p;
      req_h = h;
      run($urandom_range(300, 1500));
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        run($urandom_range(1, 10));
        enable = 1'b1;
      end
    end
    run(GATE + 10);

    enable = 1'b0;
    run(20);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
